edp_muldiv_seq: RTL and testbench

- Microsequencer that drives the EDP datapath controls (AD function, AR/ARX load, MQ shift) for iterative 36-bit multiply and non-restoring divide.
- Sits between the EBOX CRAM decode and the EDP. While busy, its control outputs replace the CRAM-driven fields.
- Observes AD sign and MQ bit 35 fed back from the EDP and sequences one step per eboxClk.

---
 rtl/edp_muldiv_seq.sv | 141 ++++++++++++++
 tb/tb_edp_muldiv_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/edp_muldiv_seq.sv
// rtl/edp_muldiv_seq.sv - EDP multiply / non-restoring divide microsequencer
module edp_muldiv_seq #(
    parameter int STEPS = 36,
    parameter int CNT_W = 6
) (
    input  logic             eboxClk,
    input  logic             eboxReset,
    input  logic             start,
    input  logic             opDiv,
    input  logic             abort,
    input  logic             adSign,
    input  logic             mqLsb,
    output logic             busy,
    output logic             done,
    output logic             divOverflow,
    output logic [6:0]       seqAD,
    output logic             seqARload,
    output logic             seqARXload,
    output logic [1:0]       seqMQsel,
    output logic             seqQbit,
    output logic [CNT_W-1:0] stepCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [6:0] AD_A_PLUS_B  = 7'h06;
    localparam logic [6:0] AD_A_MINUS_B = 7'h51;
    localparam logic [6:0] AD_A         = 7'h37;

    localparam logic [1:0] MQ_SHL  = 2'b01;
    localparam logic [1:0] MQ_SHR  = 2'b10;
    localparam logic [1:0] MQ_HOLD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state;
    logic             op_div;
    logic             prev_neg;
    logic             div_ovf;
    logic [CNT_W-1:0] step_cnt;

    always_ff @(posedge eboxClk) begin
        if (eboxReset || (abort && state != S_IDLE)) begin
            state    <= S_IDLE;
            op_div   <= 1'b0;
            prev_neg <= 1'b0;
            div_ovf  <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_div   <= opDiv;
                        prev_neg <= 1'b0;
                        step_cnt <= CNT_LOAD;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Trial subtract of the high dividend: non-negative means quotient overflow
                    if (op_div && !adSign) begin
                        div_ovf <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        prev_neg <= 1'b0;
                        state    <= S_STEP;
                    end
                end
                S_STEP: begin
                    step_cnt <= step_cnt - CNT_ONE;
                    if (op_div) begin
                        prev_neg <= adSign;
                    end
                    if (step_cnt == CNT_ONE) begin
                        state <= op_div ? S_FIXUP : S_DONE;
                    end
                end
                S_FIXUP: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    div_ovf  <= 1'b0;
                    op_div   <= 1'b0;
                    step_cnt <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        seqAD      = AD_A;
        seqARload  = 1'b0;
        seqARXload = 1'b0;
        seqMQsel   = MQ_HOLD;
        seqQbit    = 1'b0;
        case (state)
            S_SETUP: begin
                if (op_div) begin
                    seqAD = AD_A_MINUS_B;
                end
            end
            S_STEP: begin
                seqARload  = 1'b1;
                seqARXload = 1'b1;
                if (op_div) begin
                    // Non-restoring: add back after a negative partial remainder
                    seqAD    = prev_neg ? AD_A_PLUS_B : AD_A_MINUS_B;
                    seqMQsel = MQ_SHL;
                    seqQbit  = ~adSign;
                end else begin
                    seqAD    = mqLsb ? AD_A_PLUS_B : AD_A;
                    seqMQsel = MQ_SHR;
                end
            end
            S_FIXUP: begin
                if (prev_neg) begin
                    seqAD     = AD_A_PLUS_B;
                    seqARload = 1'b1;
                end
            end
            default: begin
                seqAD = AD_A;
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign divOverflow = div_ovf;
    assign stepCount   = step_cnt;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// tb/tb_edp_muldiv_seq.sv - scoreboard bench for edp_muldiv_seq
module tb_edp_muldiv_seq;

    localparam int STEPS = 36;
    localparam int CNT_W = 6;

    localparam logic [6:0] APB  = 7'h06;
    localparam logic [6:0] AMB  = 7'h51;
    localparam logic [6:0] A    = 7'h37;
    localparam logic [1:0] SHL  = 2'b01;
    localparam logic [1:0] SHR  = 2'b10;
    localparam logic [1:0] HOLD = 2'b11;

    logic             eboxClk = 1'b0;
    logic             eboxReset;
    logic             start;
    logic             opDiv;
    logic             abort;
    logic             adSign;
    logic             mqLsb;
    logic             busy;
    logic             done;
    logic             divOverflow;
    logic [6:0]       seqAD;
    logic             seqARload;
    logic             seqARXload;
    logic [1:0]       seqMQsel;
    logic             seqQbit;
    logic [CNT_W-1:0] stepCount;

    edp_muldiv_seq #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .eboxClk    (eboxClk),
        .eboxReset  (eboxReset),
        .start      (start),
        .opDiv      (opDiv),
        .abort      (abort),
        .adSign     (adSign),
        .mqLsb      (mqLsb),
        .busy       (busy),
        .done       (done),
        .divOverflow(divOverflow),
        .seqAD      (seqAD),
        .seqARload  (seqARload),
        .seqARXload (seqARXload),
        .seqMQsel   (seqMQsel),
        .seqQbit    (seqQbit),
        .stepCount  (stepCount)
    );

    always #5 eboxClk = ~eboxClk;

    typedef struct {
        logic [6:0]       ad;
        logic             arl;
        logic             arxl;
        logic [1:0]       mq;
        logic             qbit;
        logic             dn;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
        logic             cnt_chk;
        int               k;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_done   = 0;
    int   exp_done = 0;
    bit   mon_en   = 1'b0;

    function automatic exp_t mk(input int k, input logic [6:0] ad, input logic arl,
                                input logic arxl, input logic [1:0] mq, input logic qbit,
                                input logic dn, input logic ovf, input int cnt,
                                input logic chk);
        exp_t e;
        e.ad = ad; e.arl = arl; e.arxl = arxl; e.mq = mq; e.qbit = qbit;
        e.dn = dn; e.ovf = ovf; e.cnt = CNT_W'(cnt); e.cnt_chk = chk; e.k = k;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge eboxClk) begin
        if (mon_en) begin
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("busy_unexpected", 32'(busy), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("ctl k=%0d", mon_e.k),
                          32'({seqAD, seqARload, seqARXload, seqMQsel, seqQbit, done, divOverflow}),
                          32'({mon_e.ad, mon_e.arl, mon_e.arxl, mon_e.mq, mon_e.qbit, mon_e.dn, mon_e.ovf}));
                    if (mon_e.cnt_chk)
                        check($sformatf("cnt k=%0d", mon_e.k), 32'(stepCount), 32'(mon_e.cnt));
                end
            end else if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check($sformatf("busy k=%0d", mon_e.k), 32'(busy), 32'd1);
            end else begin
                check("idle", 32'({busy, done, divOverflow, seqARload, seqARXload, seqMQsel, seqAD, seqQbit, stepCount}),
                      32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HOLD, A, 1'b0, CNT_W'(0)}));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            start  = 1'b0;
            abort  = 1'($urandom % 2);
            adSign = 1'($urandom % 2);
            mqLsb  = 1'($urandom % 2);
            @(posedge eboxClk); #1;
        end
        abort = 1'b0;
    endtask

    // pat: 0 random, 1 alternating test-plan pattern, 2 forced divide overflow
    task automatic run_op(input logic div, input int pat, input int abort_at,
                          input int reset_at, input bit stray);
        exp_t e;
        int   k;
        int   last;
        logic prev;
        logic ovf;
        bit   fin;
        start  = 1'b1;
        opDiv  = div;
        abort  = (pat == 0) ? 1'($urandom % 2) : 1'b0;
        adSign = 1'($urandom % 2);
        mqLsb  = 1'($urandom % 2);
        @(posedge eboxClk); #1;
        start = 1'b0;
        k = 1; prev = 1'b0; ovf = 1'b0; fin = 1'b0;
        last = div ? STEPS + 3 : STEPS + 2;
        while (!fin) begin
            opDiv = 1'($urandom % 2);
            if (pat == 1) begin
                mqLsb  = (k % 2 == 0);
                adSign = (k == 1) ? 1'b1 : (k % 2 == 1);
            end else if (pat == 2) begin
                mqLsb  = 1'($urandom % 2);
                adSign = (k == 1) ? 1'b0 : 1'($urandom % 2);
            end else begin
                mqLsb  = 1'($urandom % 2);
                adSign = (k == 1) ? ($urandom % 4 != 0) : 1'($urandom % 2);
            end
            start     = stray && (k == 5 || k == last);
            abort     = (k == abort_at);
            eboxReset = (k == reset_at);
            if (k == 1) begin
                e = mk(k, div ? AMB : A, 0, 0, HOLD, 0, 0, 0, STEPS, 1);
                if (div && !adSign) begin
                    ovf  = 1'b1;
                    last = 2;
                end
            end else if (k == last) begin
                e = mk(k, A, 0, 0, HOLD, 0, 1, ovf, 0, !ovf);
            end else if (k <= STEPS + 1) begin
                if (div) begin
                    e = mk(k, prev ? APB : AMB, 1, 1, SHL, ~adSign, 0, 0, STEPS - (k - 2), 1);
                    prev = adSign;
                end else begin
                    e = mk(k, mqLsb ? APB : A, 1, 1, SHR, 0, 0, 0, STEPS - (k - 2), 1);
                end
            end else begin
                e = mk(k, prev ? APB : A, prev, 0, HOLD, 0, 0, 0, 0, 1);
            end
            exp_q.push_back(e);
            if (k == abort_at || k == reset_at) begin
                fin = 1'b1;
            end else if (k == last) begin
                fin = 1'b1;
                exp_done++;
            end
            @(posedge eboxClk); #1;
            k++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (reset_at > 0) begin
            @(posedge eboxClk); #1;
            eboxReset = 1'b0;
        end
    endtask

    initial begin
        eboxReset = 1'b1;
        start     = 1'b0;
        opDiv     = 1'b0;
        abort     = 1'b0;
        adSign    = 1'b0;
        mqLsb     = 1'b0;
        repeat (2) @(posedge eboxClk);
        #1;
        eboxReset = 1'b0;
        mon_en    = 1'b1;
        idle(3);
        run_op(1'b0, 1, 0, 0, 1'b0); idle(2);
        run_op(1'b1, 1, 0, 0, 1'b0); idle(2);
        run_op(1'b1, 2, 0, 0, 1'b0); idle(2);
        run_op(1'b0, 0, 11, 0, 1'b0);
        run_op(1'b0, 0, 0, 0, 1'b0); idle(2);
        run_op(1'b0, 0, 0, 20, 1'b0); idle(2);
        run_op(1'b0, 0, 0, 0, 1'b1); idle(3);
        run_op(1'b1, 1, 0, 0, 1'b1); idle(3);
        repeat (20) begin
            run_op(1'($urandom % 2), 0, 0, 0, 1'b0);
            idle(int'($urandom % 3));
        end
        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
